xil_tiny_prbs_checker: RTL and testbench
========================================

Name: xil_tiny_prbs_checker

Overview:
Serial PRBS checker that sits directly downstream of the team's tiny SRL-based LFSR generators, or at the far end of a link carrying their bitstream. It self-synchronises to an incoming pseudorandom 0/1 stream, declares lock, then free-runs a local reference and counts bit errors. A lock state machine drops lock on an error burst and re-hunts. Used for link BER tests and for checking generator wiring.

Parameters:
LFSR, "LFSR33", polynomial select: "LFSR6"/"LFSR7"/"LFSR15"/"LFSR22"/"LFSR33" gives (L,K) = (6,5)/(7,6)/(15,14)/(22,21)/(33,20); recurrence b[n]=b[n-L]^b[n-K].
LOCK_COUNT, 32, consecutive correct predictions required to lock (>=1).
WINDOW, 256, bits per lock-loss evaluation window (>=2).
UNLOCK_ERRS, 16, errors within one window that force loss of lock (1..WINDOW).
CNT_W, 32, width of error and bit counters.

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous, active-high reset
ce_i  in  1  bit_i valid qualifier; logic advances only when high
bit_i  in  1  received PRBS bit
clear_i  in  1  synchronous clear of err_count_o/bit_count_o
locked_o  out  1  checker locked
err_o  out  1  one-cycle pulse per mismatching bit while locked
err_count_o  out  CNT_W  saturating error count
bit_count_o  out  CNT_W  saturating count of bits checked while locked

Behaviour:
- Reset (async assert, sync release): state HUNT, history=0, fill/match/window counters=0, all outputs 0.
- History: L-bit shift register; h[0]=most recent bit. pred = h[L-1]^h[K-1].
- All state changes only on ce_i=1. ce_i=0: nothing changes, err_o=0.
- HUNT: shift bit_i into history; fill_cnt increments. When the L-th bit shifts in -> SYNC, match_cnt=0.
- SYNC: compare bit_i to pred; shift bit_i in (self-synchronising).
  - Match with history nonzero: match_cnt++.
  - Mismatch, or history all-zero: match_cnt=0. All-zero history never counts as a match (lockup state).
  - If the LOCK_COUNT-th consecutive match occurs -> LOCKED; window_cnt=0, win_errs=0.
- LOCKED: shift pred (not bit_i) into history, so one flipped input bit yields exactly one error.
  - mismatch = bit_i^pred. err_o registered: high on the cycle after the ce_i sample that mismatched.
  - bit_count_o++ per sample; err_count_o++ per mismatch. Both saturate at 2^CNT_W-1 with no wrap.
  - window_cnt counts 0..WINDOW-1 and then wraps; win_errs clears at wrap.
  - If win_errs reaches UNLOCK_ERRS: go to HUNT, fill_cnt=0. locked_o falls on the cycle after that sample.
  - The wrap sample and its error are evaluated before the window clears.
- locked_o is registered: high from the cycle after the sample that completes the lock.
- clear_i: counters are set to 0 next cycle. If clear_i coincides with a counted event, clear wins and the count is 0. err_o still pulses. clear_i does not affect state or locked_o.
- Async reset mid-lock: outputs go to 0 immediately. A full re-hunt follows (L + LOCK_COUNT samples).
- Lock latency from reset on a clean stream: L + LOCK_COUNT ce samples, plus 1 clock for locked_o.

Decomposition:
- Package xil_prbs_pkg holds:
  - State enum {HUNT, SYNC, LOCKED}.
  - Functions prbs_len(LFSR) and prbs_tap(LFSR) returning L and K.
  - Elaboration check that LFSR is legal.
- One sub-module, xil_prbs_ref: L-bit history, select input (bit_i vs pred), pred output and zero flag.
- The FSM, counters and saturation stay in the top level.

Test Plan:
1. LFSR7, LOCK_COUNT=16, clean stream seeded 7'h7F, ce_i=1 -> locked_o rises 24 clocks after reset release; after 1000 further bits err_count_o=0, bit_count_o=1000.
2. LFSR33 locked; invert bit 500 only -> exactly one err_o pulse one cycle after that sample; err_count_o=1, not 3; locked_o stays 1.
3. All-zero input for 500 samples, each LFSR setting -> locked_o never asserts; err_count_o=0.
4. LFSR15, WINDOW=64, UNLOCK_ERRS=8; after lock, invert the stream continuously -> 8 consecutive err_o pulses; locked_o falls one cycle after the 8th. The inverted m-sequence never re-locks: locked_o stays 0 for 2000 samples.
5. Repeat scenario 1 with ce_i randomly 50% duty -> identical lock sample index and counts; err_o never high while ce_i=0.
6. CNT_W=4 with errors injected every 3rd bit inside windows below threshold -> err_count_o saturates at 15. clear_i coinciding with an error gives 0. Async rst_i mid-lock zeroes all outputs at once, then re-lock after L+LOCK_COUNT samples.

Source files
------------

// File: rtl/xil_prbs_pkg.sv
// Shared types and polynomial lookup for the tiny PRBS checker.
package xil_prbs_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } prbs_state_e;

  // Register length L for a polynomial name; 0 flags an unsupported name.
  function automatic int unsigned prbs_len(input string lfsr);
    if (lfsr == "LFSR6")  return 6;
    if (lfsr == "LFSR7")  return 7;
    if (lfsr == "LFSR15") return 15;
    if (lfsr == "LFSR22") return 22;
    if (lfsr == "LFSR33") return 33;
    return 0;
  endfunction

  // Inner tap K of the recurrence b[n] = b[n-L] ^ b[n-K].
  function automatic int unsigned prbs_tap(input string lfsr);
    if (lfsr == "LFSR6")  return 5;
    if (lfsr == "LFSR7")  return 6;
    if (lfsr == "LFSR15") return 14;
    if (lfsr == "LFSR22") return 21;
    if (lfsr == "LFSR33") return 20;
    return 0;
  endfunction

  function automatic bit prbs_legal(input string lfsr);
    return prbs_len(lfsr) != 0;
  endfunction

endpackage

// File: rtl/xil_prbs_ref.sv
// Local PRBS reference: L-bit history fed either by the received bit
// (self-synchronising) or by its own prediction (free-running).
module xil_prbs_ref
  import xil_prbs_pkg::*;
#(
  parameter int unsigned L = 33,
  parameter int unsigned K = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ce_i,
  input  logic sel_pred_i,
  input  logic bit_i,
  output logic pred_c_o,
  output logic zero_c_o
);

  logic [L-1:0] hist_q, hist_d;
  logic         shift_bit;

  // Prediction, lockup detect and next history; h[0] is the newest bit.
  always_comb begin
    pred_c_o  = hist_q[L-1] ^ hist_q[K-1];
    zero_c_o  = (hist_q == '0);
    shift_bit = sel_pred_i ? pred_c_o : bit_i;
    hist_d    = hist_q;
    if (ce_i) begin
      hist_d = {hist_q[L-2:0], shift_bit};
    end
  end

  // History register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hist_q <= '0;
    end else begin
      hist_q <= hist_d;
    end
  end

endmodule

// File: rtl/xil_tiny_prbs_checker.sv
// Serial PRBS checker: hunts, syncs, locks, then counts bit errors and
// drops lock when too many errors land in one window.
module xil_tiny_prbs_checker
  import xil_prbs_pkg::*;
#(
  parameter string       LFSR        = "LFSR33",
  parameter int unsigned LOCK_COUNT  = 32,
  parameter int unsigned WINDOW      = 256,
  parameter int unsigned UNLOCK_ERRS = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic             bit_i,
  input  logic             clear_i,
  output logic             locked_o,
  output logic             err_o,
  output logic [CNT_W-1:0] err_count_o,
  output logic [CNT_W-1:0] bit_count_o
);

  localparam int unsigned L       = prbs_len(LFSR);
  localparam int unsigned K       = prbs_tap(LFSR);
  localparam int unsigned FILL_W  = $clog2(L + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
  localparam int unsigned WIN_W   = $clog2(WINDOW);
  localparam int unsigned WERR_W  = $clog2(UNLOCK_ERRS + 1);

  if (!prbs_legal(LFSR) || LOCK_COUNT < 1 || WINDOW < 2 ||
      UNLOCK_ERRS < 1 || UNLOCK_ERRS > WINDOW) begin : g_bad_param
    $error("xil_tiny_prbs_checker: illegal parameter setting");
  end

  prbs_state_e        state_q, state_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]  win_errs_q, win_errs_d;
  logic [WERR_W-1:0]  win_errs_nxt;
  logic               err_q, err_d;
  logic               locked_q, locked_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;
  logic               sel_pred;
  logic               pred;
  logic               zero;
  logic               mismatch;

  xil_prbs_ref #(
    .L (L),
    .K (K)
  ) u_ref (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .ce_i       (ce_i),
    .sel_pred_i (sel_pred),
    .bit_i      (bit_i),
    .pred_c_o   (pred),
    .zero_c_o   (zero)
  );

  // Lock FSM, window tracking and saturating counters.
  always_comb begin
    state_d      = state_q;
    fill_d       = fill_q;
    match_d      = match_q;
    win_cnt_d    = win_cnt_q;
    win_errs_d   = win_errs_q;
    err_d        = 1'b0;
    locked_d     = locked_q;
    err_count_d  = err_count_q;
    bit_count_d  = bit_count_q;
    sel_pred     = (state_q == LOCKED);
    mismatch     = bit_i ^ pred;
    win_errs_nxt = win_errs_q + WERR_W'(mismatch);

    if (ce_i) begin
      unique case (state_q)
        HUNT: begin
          fill_d = fill_q + FILL_W'(1);
          if (fill_q == FILL_W'(L - 1)) begin
            state_d = SYNC;
            match_d = '0;
          end
        end
        SYNC: begin
          // An all-zero history predicts zero forever, so it never counts.
          if (!mismatch && !zero) begin
            if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
              state_d    = LOCKED;
              locked_d   = 1'b1;
              win_cnt_d  = '0;
              win_errs_d = '0;
            end else begin
              match_d = match_q + MATCH_W'(1);
            end
          end else begin
            match_d = '0;
          end
        end
        LOCKED: begin
          err_d = mismatch;
          if (bit_count_q != '1) begin
            bit_count_d = bit_count_q + CNT_W'(1);
          end
          if (mismatch && (err_count_q != '1)) begin
            err_count_d = err_count_q + CNT_W'(1);
          end
          // The wrap sample's error is judged before the window restarts.
          if (win_errs_nxt == WERR_W'(UNLOCK_ERRS)) begin
            state_d  = HUNT;
            locked_d = 1'b0;
            fill_d   = '0;
          end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
            win_cnt_d  = '0;
            win_errs_d = '0;
          end else begin
            win_cnt_d  = win_cnt_q + WIN_W'(1);
            win_errs_d = win_errs_nxt;
          end
        end
        default: begin
          state_d = HUNT;
        end
      endcase
    end

    if (clear_i) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= HUNT;
      fill_q      <= '0;
      match_q     <= '0;
      win_cnt_q   <= '0;
      win_errs_q  <= '0;
      err_q       <= 1'b0;
      locked_q    <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_cnt_q   <= win_cnt_d;
      win_errs_q  <= win_errs_d;
      err_q       <= err_d;
      locked_q    <= locked_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign locked_o    = locked_q;
  assign err_o       = err_q;
  assign err_count_o = err_count_q;
  assign bit_count_o = bit_count_q;

endmodule

// File: tb/tb_xil_tiny_prbs_checker.sv
// Self-checking bench for xil_tiny_prbs_checker: several parameterisations
// driven with generated PRBS streams and compared against stream-level
// expectations (lock sample index, flipped-bit counts, saturation).
module tb_xil_tiny_prbs_checker;

  localparam int ND = 6;
  // Per-instance polynomial length, inner tap and lock count.
  localparam int LEN  [ND] = '{7, 33, 15, 7, 22, 6};
  localparam int TAP  [ND] = '{6, 20, 14, 6, 21, 5};
  localparam int LCNT [ND] = '{16, 32, 32, 16, 32, 32};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [ND];
  logic        ce  [ND];
  logic        bi  [ND];
  logic        clr [ND];
  logic        lk  [ND];
  logic        er  [ND];
  logic [31:0] ec  [ND];
  logic [31:0] bc  [ND];
  logic [3:0]  ec_d, bc_d;

  assign ec[3] = 32'(ec_d);
  assign bc[3] = 32'(bc_d);

  int errors = 0;
  int checks = 0;
  bit s_q[$];

  xil_tiny_prbs_checker #(.LFSR("LFSR7"), .LOCK_COUNT(16)) u_a (
    .clk_i(clk), .rst_i(rst[0]), .ce_i(ce[0]), .bit_i(bi[0]), .clear_i(clr[0]),
    .locked_o(lk[0]), .err_o(er[0]), .err_count_o(ec[0]), .bit_count_o(bc[0]));

  xil_tiny_prbs_checker #(.LFSR("LFSR33")) u_b (
    .clk_i(clk), .rst_i(rst[1]), .ce_i(ce[1]), .bit_i(bi[1]), .clear_i(clr[1]),
    .locked_o(lk[1]), .err_o(er[1]), .err_count_o(ec[1]), .bit_count_o(bc[1]));

  xil_tiny_prbs_checker #(.LFSR("LFSR15"), .WINDOW(64), .UNLOCK_ERRS(8)) u_c (
    .clk_i(clk), .rst_i(rst[2]), .ce_i(ce[2]), .bit_i(bi[2]), .clear_i(clr[2]),
    .locked_o(lk[2]), .err_o(er[2]), .err_count_o(ec[2]), .bit_count_o(bc[2]));

  xil_tiny_prbs_checker #(.LFSR("LFSR7"), .LOCK_COUNT(16), .WINDOW(64),
                          .UNLOCK_ERRS(32), .CNT_W(4)) u_d (
    .clk_i(clk), .rst_i(rst[3]), .ce_i(ce[3]), .bit_i(bi[3]), .clear_i(clr[3]),
    .locked_o(lk[3]), .err_o(er[3]), .err_count_o(ec_d), .bit_count_o(bc_d));

  xil_tiny_prbs_checker #(.LFSR("LFSR22")) u_e (
    .clk_i(clk), .rst_i(rst[4]), .ce_i(ce[4]), .bit_i(bi[4]), .clear_i(clr[4]),
    .locked_o(lk[4]), .err_o(er[4]), .err_count_o(ec[4]), .bit_count_o(bc[4]));

  xil_tiny_prbs_checker #(.LFSR("LFSR6")) u_f (
    .clk_i(clk), .rst_i(rst[5]), .ce_i(ce[5]), .bit_i(bi[5]), .clear_i(clr[5]),
    .locked_o(lk[5]), .err_o(er[5]), .err_count_o(ec[5]), .bit_count_o(bc[5]));

  // Reference stream: L seed bits, then b[n] = b[n-L] ^ b[n-K].
  task automatic make_stream(input int idx, input logic [63:0] seed, input int n);
    s_q.delete();
    for (int i = 0; i < LEN[idx]; i++) s_q.push_back(seed[i]);
    while (s_q.size() < n)
      s_q.push_back(s_q[s_q.size() - LEN[idx]] ^ s_q[s_q.size() - TAP[idx]]);
  endtask

  function automatic logic [63:0] rand_seed(input int idx);
    logic [63:0] s;
    s = {32'($urandom), 32'($urandom)} & ((64'd1 << LEN[idx]) - 64'd1);
    if (s == 64'd0) s = 64'd1;
    return s;
  endfunction

  // One clock with the given inputs on one instance; returns #1 after the edge.
  task automatic step(input int idx, input logic c, input logic b, input logic cl);
    ce[idx] = c; bi[idx] = b; clr[idx] = cl;
    @(posedge clk); #1;
    ce[idx] = 1'b0; clr[idx] = 1'b0;
  endtask

  task automatic pulse_reset(input int idx);
    rst[idx] = 1'b1;
    @(posedge clk); #1;
    rst[idx] = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < ND; i++) begin
      rst[i] = 1'b1; ce[i] = 1'b0; bi[i] = 1'b0; clr[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < ND; i++) begin
      checks++;
      if (lk[i] !== 1'b0 || er[i] !== 1'b0 || ec[i] !== 32'd0 || bc[i] !== 32'd0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d: locked=%b err=%b errs=%0d bits=%0d expected all 0",
                 i, lk[i], er[i], ec[i], bc[i]);
      end
      rst[i] = 1'b0;
    end
  endtask

  task automatic test_clean_lock();
    int lock_at, n, seen, pulses;
    lock_at = LEN[0] + LCNT[0];
    n = lock_at + 1000;
    make_stream(0, 64'h7F, n);
    seen = -1; pulses = 0;
    for (int s = 1; s <= n; s++) begin
      step(0, 1'b1, s_q[s-1], 1'b0);
      if (lk[0] === 1'b1 && seen < 0) seen = s;
      if (er[0] === 1'b1) pulses++;
    end
    checks++; if (seen != lock_at) begin errors++;
      $display("FAIL clean_lock_sample: got %0d expected %0d", seen, lock_at); end
    checks++; if (pulses != 0) begin errors++;
      $display("FAIL clean_err_pulses: got %0d expected 0", pulses); end
    checks++; if (ec[0] !== 32'd0) begin errors++;
      $display("FAIL clean_err_count: got %0d expected 0", ec[0]); end
    checks++; if (bc[0] !== 32'd1000) begin errors++;
      $display("FAIL clean_bit_count: got %0d expected 1000", bc[0]); end
    checks++; if (lk[0] !== 1'b1) begin errors++;
      $display("FAIL clean_still_locked: got %b expected 1", lk[0]); end
  endtask

  task automatic test_single_flip();
    int lock_at, n, flip_at, seen, pulses, pulse_s;
    lock_at = LEN[1] + LCNT[1];
    flip_at = lock_at + 500;
    n = lock_at + 1000;
    make_stream(1, rand_seed(1), n);
    seen = -1; pulses = 0; pulse_s = -1;
    for (int s = 1; s <= n; s++) begin
      step(1, 1'b1, s_q[s-1] ^ (s == flip_at), 1'b0);
      if (lk[1] === 1'b1 && seen < 0) seen = s;
      if (er[1] === 1'b1) begin pulses++; pulse_s = s; end
    end
    checks++; if (seen != lock_at) begin errors++;
      $display("FAIL flip_lock_sample: got %0d expected %0d", seen, lock_at); end
    checks++; if (pulses != 1) begin errors++;
      $display("FAIL flip_pulse_count: got %0d expected 1", pulses); end
    checks++; if (pulse_s != flip_at) begin errors++;
      $display("FAIL flip_pulse_sample: got %0d expected %0d", pulse_s, flip_at); end
    checks++; if (ec[1] !== 32'd1) begin errors++;
      $display("FAIL flip_err_count: got %0d expected 1", ec[1]); end
    checks++; if (bc[1] !== 32'd1000) begin errors++;
      $display("FAIL flip_bit_count: got %0d expected 1000", bc[1]); end
    checks++; if (lk[1] !== 1'b1) begin errors++;
      $display("FAIL flip_still_locked: got %b expected 1", lk[1]); end
  endtask

  task automatic test_invert_unlock();
    int lock_at, inv_from, n, seen, pulses, first_p, last_p, unlock_s, relock;
    lock_at = LEN[2] + LCNT[2];
    inv_from = lock_at + 21;
    n = inv_from + 2007;
    make_stream(2, rand_seed(2), n);
    seen = -1; pulses = 0; first_p = -1; last_p = -1; unlock_s = -1; relock = 0;
    for (int s = 1; s <= n; s++) begin
      step(2, 1'b1, s_q[s-1] ^ (s >= inv_from), 1'b0);
      if (lk[2] === 1'b1 && seen < 0) seen = s;
      if (seen > 0 && unlock_s < 0 && lk[2] === 1'b0) unlock_s = s;
      if (unlock_s > 0 && lk[2] === 1'b1) relock++;
      if (er[2] === 1'b1) begin
        pulses++; last_p = s;
        if (first_p < 0) first_p = s;
      end
    end
    checks++; if (seen != lock_at) begin errors++;
      $display("FAIL inv_lock_sample: got %0d expected %0d", seen, lock_at); end
    checks++; if (pulses != 8 || first_p != inv_from || last_p != inv_from + 7) begin errors++;
      $display("FAIL inv_err_pulses: got %0d pulses at %0d..%0d expected 8 at %0d..%0d",
               pulses, first_p, last_p, inv_from, inv_from + 7); end
    checks++; if (unlock_s != inv_from + 7) begin errors++;
      $display("FAIL inv_unlock_sample: got %0d expected %0d", unlock_s, inv_from + 7); end
    checks++; if (relock != 0) begin errors++;
      $display("FAIL inv_relock_cycles: got %0d expected 0", relock); end
    checks++; if (ec[2] !== 32'd8) begin errors++;
      $display("FAIL inv_err_count: got %0d expected 8", ec[2]); end
    checks++; if (bc[2] !== 32'(inv_from + 7 - lock_at)) begin errors++;
      $display("FAIL inv_bit_count: got %0d expected %0d", bc[2], inv_from + 7 - lock_at); end
  endtask

  task automatic test_zero_input();
    int ever [ND];
    for (int i = 0; i < ND; i++) begin rst[i] = 1'b1; ever[i] = 0; end
    @(posedge clk); #1;
    for (int i = 0; i < ND; i++) rst[i] = 1'b0;
    for (int s = 0; s < 500; s++) begin
      for (int i = 0; i < ND; i++) begin ce[i] = 1'b1; bi[i] = 1'b0; end
      @(posedge clk); #1;
      for (int i = 0; i < ND; i++) if (lk[i] === 1'b1) ever[i]++;
    end
    for (int i = 0; i < ND; i++) begin
      ce[i] = 1'b0;
      checks++; if (ever[i] != 0) begin errors++;
        $display("FAIL zero_locked dut%0d: locked for %0d cycles expected 0", i, ever[i]); end
      checks++; if (ec[i] !== 32'd0) begin errors++;
        $display("FAIL zero_err_count dut%0d: got %0d expected 0", i, ec[i]); end
    end
  endtask

  task automatic test_random_ce();
    int lock_at, n, ce_cnt, cyc, seen, pulses, bad, f1, f2, f3;
    logic c, b;
    pulse_reset(0);
    lock_at = LEN[0] + LCNT[0];
    n = lock_at + 1000;
    make_stream(0, 64'h7F, n);
    f1 = lock_at + $urandom_range(100, 300);
    f2 = lock_at + $urandom_range(400, 600);
    f3 = lock_at + $urandom_range(700, 999);
    ce_cnt = 0; cyc = 0; seen = -1; pulses = 0; bad = 0;
    while (ce_cnt < n && cyc < 20 * n) begin
      cyc++;
      c = 1'($urandom_range(0, 1));
      if (c) begin
        ce_cnt++;
        b = s_q[ce_cnt-1] ^ (ce_cnt == f1 || ce_cnt == f2 || ce_cnt == f3);
      end else begin
        b = 1'($urandom_range(0, 1));
      end
      step(0, c, b, 1'b0);
      if (lk[0] === 1'b1 && seen < 0) seen = ce_cnt;
      if (er[0] === 1'b1) begin
        if (c) pulses++;
        else bad++;
      end
    end
    checks++; if (ce_cnt != n) begin errors++;
      $display("FAIL rce_budget: delivered %0d samples expected %0d", ce_cnt, n); end
    checks++; if (seen != lock_at) begin errors++;
      $display("FAIL rce_lock_sample: got %0d expected %0d", seen, lock_at); end
    checks++; if (bad != 0) begin errors++;
      $display("FAIL rce_err_after_idle: got %0d expected 0", bad); end
    checks++; if (pulses != 3) begin errors++;
      $display("FAIL rce_err_pulses: got %0d expected 3", pulses); end
    checks++; if (ec[0] !== 32'd3) begin errors++;
      $display("FAIL rce_err_count: got %0d expected 3", ec[0]); end
    checks++; if (bc[0] !== 32'd1000) begin errors++;
      $display("FAIL rce_bit_count: got %0d expected 1000", bc[0]); end
  endtask

  task automatic test_saturate();
    int lock_at, n, s, pulses, seen, exp_e, exp_b;
    lock_at = LEN[3] + LCNT[3];
    n = lock_at + 123 + lock_at + 10;
    make_stream(3, rand_seed(3), n);
    pulses = 0;
    for (s = 1; s <= lock_at; s++) step(3, 1'b1, s_q[s-1], 1'b0);
    for (int k = 1; k <= 120; k++) begin
      step(3, 1'b1, s_q[s-1] ^ (k % 3 == 0), 1'b0);
      s++;
      if (er[3] === 1'b1) pulses++;
    end
    exp_e = (40 > 15) ? 15 : 40;
    exp_b = (120 > 15) ? 15 : 120;
    checks++; if (ec_d !== 4'(exp_e)) begin errors++;
      $display("FAIL sat_err_count: got %0d expected %0d", ec_d, exp_e); end
    checks++; if (bc_d !== 4'(exp_b)) begin errors++;
      $display("FAIL sat_bit_count: got %0d expected %0d", bc_d, exp_b); end
    checks++; if (pulses != 40) begin errors++;
      $display("FAIL sat_err_pulses: got %0d expected 40", pulses); end
    checks++; if (lk[3] !== 1'b1) begin errors++;
      $display("FAIL sat_still_locked: got %b expected 1", lk[3]); end
    // Clear on the same sample as an error: the clear wins, err_o still pulses.
    step(3, 1'b1, ~s_q[s-1], 1'b1); s++;
    checks++; if (ec_d !== 4'd0 || bc_d !== 4'd0 || er[3] !== 1'b1) begin errors++;
      $display("FAIL clear_with_err: errs=%0d bits=%0d err=%b expected 0 0 1", ec_d, bc_d, er[3]); end
    step(3, 1'b1, s_q[s-1], 1'b0); s++;
    checks++; if (ec_d !== 4'd0 || bc_d !== 4'd1) begin errors++;
      $display("FAIL after_clear_clean: errs=%0d bits=%0d expected 0 1", ec_d, bc_d); end
    step(3, 1'b1, ~s_q[s-1], 1'b0); s++;
    checks++; if (ec_d !== 4'd1 || bc_d !== 4'd2 || er[3] !== 1'b1) begin errors++;
      $display("FAIL after_clear_err: errs=%0d bits=%0d err=%b expected 1 2 1", ec_d, bc_d, er[3]); end
    // Asynchronous reset between clock edges.
    rst[3] = 1'b1;
    #2;
    checks++; if (lk[3] !== 1'b0 || er[3] !== 1'b0 || ec_d !== 4'd0 || bc_d !== 4'd0) begin errors++;
      $display("FAIL async_reset: locked=%b err=%b errs=%0d bits=%0d expected all 0",
               lk[3], er[3], ec_d, bc_d); end
    @(posedge clk); #1;
    rst[3] = 1'b0;
    seen = -1;
    for (int r = 1; r <= lock_at + 5; r++) begin
      step(3, 1'b1, s_q[s-1], 1'b0); s++;
      if (lk[3] === 1'b1 && seen < 0) seen = r;
    end
    checks++; if (seen != lock_at) begin errors++;
      $display("FAIL relock_sample: got %0d expected %0d", seen, lock_at); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_lock();
    test_single_flip();
    test_invert_unlock();
    test_zero_input();
    test_random_ce();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
